// File: rtl/writeback_stage_if.sv
// writeback_stage_if
//   Bundles the memory-stage handshake, the decoupled load-response port and
//   the register-file write/retire outputs of the writeback stage.
//   Parameters: XLEN (32/64 datapath width), NREG (register count).
//   Modports:
//     master - upstream/environment side: drives instruction + load response,
//              observes ready and the writeback outputs.
//     slave  - the writeback stage itself.
interface writeback_stage_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int RW = $clog2(NREG);

    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] alu_result_i;
    logic [XLEN-1:0] pc_plus4_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            rf_we_o;
    logic [RW-1:0]   rf_rd_o;
    logic [XLEN-1:0] rf_data_o;
    logic            retire_o;
    logic            trap_o;
    logic [XLEN-1:0] trap_addr_o;

    modport master (
        output in_valid_i, instr_i, alu_result_i, pc_plus4_i, mem_rvalid_i, mem_rdata_i,
        input  in_ready_o, rf_we_o, rf_rd_o, rf_data_o, retire_o, trap_o, trap_addr_o
    );

    modport slave (
        input  in_valid_i, instr_i, alu_result_i, pc_plus4_i, mem_rvalid_i, mem_rdata_i,
        output in_ready_o, rf_we_o, rf_rd_o, rf_data_o, retire_o, trap_o, trap_addr_o
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage
//   RV32/RV64 writeback stage. Accepts one instruction per cycle from the
//   memory stage, picks the result source by opcode, formats load data
//   (byte-lane select + sign/zero extension) and drives one registered
//   register-file write port. Loads park in WAIT_MEM until the decoupled
//   load response arrives.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     flush_i      synchronous flush, drops held load / same-cycle accept
//     wb (slave)   handshake, load response, rf write, retire, trap
//   Optional feature macro: WB_MISALIGN_TRAP_EN
//     defined   - misaligned/undefined loads raise trap_o (with trap_addr_o)
//                 instead of writing and retiring
//     undefined - misaligned loads write 0 and retire; trap outputs tied 0
module writeback_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    writeback_stage_if.slave wb
);
    localparam int RW   = $clog2(NREG);
    localparam int OFFW = $clog2(XLEN/8);

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t state, state_nx;

    // latched load context
    logic [2:0]      ld_f3;
    logic [RW-1:0]   ld_rd;
    logic [OFFW-1:0] ld_off;
    logic            ld_cap;

    // registered outputs and their next values
    logic            we_q, we_nx;
    logic            ret_q, ret_nx;
    logic [RW-1:0]   rd_q, rd_nx;
    logic [XLEN-1:0] data_q, data_nx;
`ifdef WB_MISALIGN_TRAP_EN
    logic            trap_q, trap_nx;
    logic [XLEN-1:0] taddr_q, taddr_nx;
    logic [XLEN-1:0] ld_addr;
`endif

    // decode of the instruction on the input bus
    logic [6:0]    opc;
    logic [RW-1:0] rd_in;
    logic          src_alu, src_link, is_load;
    logic          unused_instr;

    assign opc      = wb.instr_i[6:0];
    assign rd_in    = wb.instr_i[7 +: RW];
    assign is_load  = (opc == OPC_LOAD);
    assign src_link = (opc == OPC_JAL) || (opc == OPC_JALR);
    assign src_alu  = (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
                      (opc == OPC_AUIPC) ||
                      ((XLEN == 64) && ((opc == OPC_OP_32) || (opc == OPC_OP_IMM_32)));
    assign unused_instr = ^wb.instr_i[31:15];

    // load formatting: shift the addressed byte lane down to bit 0, then
    // extend by funct3. Undefined funct3 is folded into ld_bad.
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] ld_data;
    logic            ld_bad;

    assign sh = wb.mem_rdata_i >> {ld_off, 3'b000};

    always_comb begin
        ld_data = '0;
        ld_bad  = 1'b0;
        case (ld_f3)
            3'b000: ld_data = XLEN'($signed(sh[7:0]));
            3'b001: begin
                ld_data = XLEN'($signed(sh[15:0]));
                ld_bad  = ld_off[0];
            end
            3'b010: begin
                ld_data = XLEN'($signed(sh[31:0]));
                ld_bad  = |ld_off[1:0];
            end
            3'b011: begin
                if (XLEN == 64) begin
                    ld_data = sh;
                    ld_bad  = |ld_off;
                end else begin
                    ld_bad  = 1'b1;
                end
            end
            3'b100: ld_data = XLEN'(sh[7:0]);
            3'b101: begin
                ld_data = XLEN'(sh[15:0]);
                ld_bad  = ld_off[0];
            end
            3'b110: begin
                if (XLEN == 64) begin
                    ld_data = XLEN'(sh[31:0]);
                    ld_bad  = |ld_off[1:0];
                end else begin
                    ld_bad  = 1'b1;
                end
            end
            default: ld_bad = 1'b1;
        endcase
    end

    // next-state / next-output logic; flush overrides everything
    always_comb begin
        state_nx = state;
        ld_cap   = 1'b0;
        we_nx    = 1'b0;
        ret_nx   = 1'b0;
        rd_nx    = rd_q;
        data_nx  = data_q;
`ifdef WB_MISALIGN_TRAP_EN
        trap_nx  = 1'b0;
        taddr_nx = taddr_q;
`endif
        if (flush_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (wb.in_valid_i) begin
                        if (is_load) begin
                            ld_cap   = 1'b1;
                            state_nx = WAIT_MEM;
                        end else begin
                            ret_nx = 1'b1;
                            // rd/data only move on a real write so they hold otherwise
                            if ((src_alu || src_link) && (rd_in != '0)) begin
                                we_nx   = 1'b1;
                                rd_nx   = rd_in;
                                data_nx = src_link ? wb.pc_plus4_i : wb.alu_result_i;
                            end
                        end
                    end
                end
                WAIT_MEM: begin
                    if (wb.mem_rvalid_i) begin
                        state_nx = IDLE;
`ifdef WB_MISALIGN_TRAP_EN
                        if (ld_bad) begin
                            trap_nx  = 1'b1;
                            taddr_nx = ld_addr;
                        end else begin
                            ret_nx = 1'b1;
                            if (ld_rd != '0) begin
                                we_nx   = 1'b1;
                                rd_nx   = ld_rd;
                                data_nx = ld_data;
                            end
                        end
`else
                        ret_nx = 1'b1;
                        if (ld_rd != '0) begin
                            we_nx   = 1'b1;
                            rd_nx   = ld_rd;
                            data_nx = ld_bad ? '0 : ld_data;
                        end
`endif
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ld_f3  <= '0;
            ld_rd  <= '0;
            ld_off <= '0;
            we_q   <= 1'b0;
            ret_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nx;
            we_q   <= we_nx;
            ret_q  <= ret_nx;
            rd_q   <= rd_nx;
            data_q <= data_nx;
            if (ld_cap) begin
                ld_f3  <= wb.instr_i[14:12];
                ld_rd  <= rd_in;
                ld_off <= wb.alu_result_i[OFFW-1:0];
            end
        end
    end

`ifdef WB_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q  <= 1'b0;
            taddr_q <= '0;
            ld_addr <= '0;
        end else begin
            trap_q  <= trap_nx;
            taddr_q <= taddr_nx;
            if (ld_cap) ld_addr <= wb.alu_result_i;
        end
    end

    assign wb.trap_o      = trap_q;
    assign wb.trap_addr_o = taddr_q;
`else
    assign wb.trap_o      = 1'b0;
    assign wb.trap_addr_o = '0;
`endif

    assign wb.in_ready_o = (state == IDLE);
    assign wb.rf_we_o    = we_q;
    assign wb.rf_rd_o    = rd_q;
    assign wb.rf_data_o  = data_q;
    assign wb.retire_o   = ret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
//   Drives an XLEN=32 and an XLEN=64 writeback stage in lockstep with the
//   same (random + directed) stimulus and compares both against a
//   behavioural model computed from the load/source rules with arithmetic.
module tb_writeback_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    writeback_stage_if #(.XLEN(32), .NREG(32)) w32 ();
    writeback_stage_if #(.XLEN(64), .NREG(32)) w64 ();

    writeback_stage #(.XLEN(32), .NREG(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush_i(flush), .wb(w32.slave));
    writeback_stage #(.XLEN(64), .NREG(32)) dut64 (.clk(clk), .rst_n(rst_n), .flush_i(flush), .wb(w64.slave));

    int n_chk = 0;
    int n_err = 0;

    // expected output state, index 0 = XLEN32, 1 = XLEN64
    bit          e_we[2], e_ret[2], e_trp[2];
    logic [4:0]  e_rd[2];
    logic [63:0] e_data[2], e_taddr[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit rdy);
        chk({tag, "/32 rdy"},   64'(w32.in_ready_o),  64'(rdy));
        chk({tag, "/32 we"},    64'(w32.rf_we_o),     64'(e_we[0]));
        chk({tag, "/32 rd"},    64'(w32.rf_rd_o),     64'(e_rd[0]));
        chk({tag, "/32 data"},  64'(w32.rf_data_o),   e_data[0]);
        chk({tag, "/32 ret"},   64'(w32.retire_o),    64'(e_ret[0]));
        chk({tag, "/32 trap"},  64'(w32.trap_o),      64'(e_trp[0]));
        chk({tag, "/32 taddr"}, 64'(w32.trap_addr_o), e_taddr[0]);
        chk({tag, "/64 rdy"},   64'(w64.in_ready_o),  64'(rdy));
        chk({tag, "/64 we"},    64'(w64.rf_we_o),     64'(e_we[1]));
        chk({tag, "/64 rd"},    64'(w64.rf_rd_o),     64'(e_rd[1]));
        chk({tag, "/64 data"},  w64.rf_data_o,        e_data[1]);
        chk({tag, "/64 ret"},   64'(w64.retire_o),    64'(e_ret[1]));
        chk({tag, "/64 trap"},  64'(w64.trap_o),      64'(e_trp[1]));
        chk({tag, "/64 taddr"}, w64.trap_addr_o,      e_taddr[1]);
    endtask

    task automatic no_pulse();
        for (int k = 0; k < 2; k++) begin
            e_we[k] = 0; e_ret[k] = 0; e_trp[k] = 0;
        end
    endtask

    // Reference: what one retired instruction does for a machine of width xl.
    function automatic void model(input int k, input logic [31:0] ins, input logic [63:0] alu,
                                  input logic [63:0] pc4, input logic [63:0] rdata);
        int          xl, f3, sz, nb, off;
        logic [63:0] m, val, lim;
        bit          wr, legal;
        xl  = (k == 0) ? 32 : 64;
        m   = (k == 0) ? 64'hFFFF_FFFF : '1;
        f3  = int'(ins[14:12]);
        wr  = 0;
        val = '0;
        e_we[k] = 0; e_ret[k] = 1; e_trp[k] = 0;
        case (ins[6:0])
            7'h33, 7'h13, 7'h37, 7'h17: begin wr = 1; val = alu & m; end
            7'h3B, 7'h1B: if (xl == 64) begin wr = 1; val = alu; end
            7'h6F, 7'h67: begin wr = 1; val = pc4 & m; end
            7'h03: begin
                sz    = 1 << (f3 % 4);
                nb    = xl / 8;
                off   = int'(alu[2:0]) % nb;
                legal = (f3 != 7) && !(xl == 32 && (f3 == 3 || f3 == 6));
                if (!legal || (off % sz) != 0) begin
`ifdef WB_MISALIGN_TRAP_EN
                    e_ret[k]   = 0;
                    e_trp[k]   = 1;
                    e_taddr[k] = alu & m;
`else
                    wr  = 1;
                    val = '0;
`endif
                end else begin
                    val = (rdata & m) >> (off * 8);
                    if (sz < 8) begin
                        lim = 64'd1 << (sz * 8);
                        val = val % lim;
                        if (f3 < 4 && val >= lim / 2) val = val - lim;
                    end
                    val = val & m;
                    wr  = 1;
                end
            end
            default: ;
        endcase
        if (wr && ins[11:7] != 5'd0) begin
            e_we[k]   = 1;
            e_rd[k]   = ins[11:7];
            e_data[k] = val;
        end
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3);
        logic [16:0] hi;
        hi = 17'($urandom());
        return {hi, f3, rd, opc};
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input logic [63:0] alu,
                         input logic [63:0] pc4, input bit rv, input logic [63:0] rd_data);
        w32.in_valid_i = v;  w32.instr_i = ins;  w32.alu_result_i = alu[31:0];
        w32.pc_plus4_i = pc4[31:0]; w32.mem_rvalid_i = rv; w32.mem_rdata_i = rd_data[31:0];
        w64.in_valid_i = v;  w64.instr_i = ins;  w64.alu_result_i = alu;
        w64.pc_plus4_i = pc4; w64.mem_rvalid_i = rv; w64.mem_rdata_i = rd_data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    // non-load instruction; junk rvalid must be ignored in IDLE
    task automatic do_op(input logic [31:0] ins, input logic [63:0] alu, input logic [63:0] pc4);
        drive(1, ins, alu, pc4, 1'($urandom()), r64());
        step();
        drive(0, ins, alu, pc4, 0, r64());
        model(0, ins, alu, pc4, '0);
        model(1, ins, alu, pc4, '0);
        check_all("op", 1);
    endtask

    task automatic do_load(input logic [31:0] ins, input logic [63:0] addr, input logic [63:0] rdata,
                           input int dly, input bit fl);
        drive(1, ins, addr, r64(), 1'($urandom()), r64());
        step();
        drive(0, ins, addr, '0, 0, '0);
        no_pulse();
        check_all("ld_acc", 0);
        for (int i = 0; i < dly; i++) begin
            // an offered instruction while busy must not be taken
            drive(1, mk(7'h33, 5'd4, 3'd0), r64(), r64(), 0, r64());
            step();
            check_all("ld_wait", 0);
        end
        drive(0, ins, addr, '0, 1, rdata);
        flush = fl;
        step();
        flush = 0;
        drive(0, ins, addr, '0, 0, '0);
        if (fl) no_pulse();
        else begin
            model(0, ins, addr, '0, rdata);
            model(1, ins, addr, '0, rdata);
        end
        check_all(fl ? "ld_flush" : "ld_rsp", 1);
    endtask

    localparam logic [6:0] NONLOAD[12] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67,
                                           7'h3B, 7'h1B, 7'h23, 7'h63, 7'h73, 7'h0F};

    initial begin
        logic [31:0] ins;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [63:0] a;
        for (int k = 0; k < 2; k++) begin
            e_rd[k] = '0; e_data[k] = '0; e_taddr[k] = '0;
        end
        no_pulse();
        drive(0, '0, '0, '0, 0, '0);
        #12;
        check_all("reset", 1);
        rst_n = 1'b1;
        step();
        check_all("idle", 1);

        // ADD rd=5 alu=0x1234, then three back-to-back ALU ops
        do_op(mk(7'h33, 5'd5, 3'd0), 64'h1234, '0);
        chk("add_data", 64'(w32.rf_data_o), 64'h1234);
        chk("add_we", 64'(w32.rf_we_o), 64'd1);
        do_op(mk(7'h13, 5'd6, 3'd0), 64'h11, '0);
        do_op(mk(7'h37, 5'd7, 3'd0), 64'h22, '0);
        do_op(mk(7'h17, 5'd8, 3'd0), 64'h33, '0);
        chk("b2b_rd", 64'(w64.rf_rd_o), 64'd8);

        // LB / LBU at byte offset 2, response three cycles after accept
        do_load(mk(7'h03, 5'd3, 3'b000), 64'h1002, 64'h0080_0000, 2, 0);
        chk("lb_data", 64'(w32.rf_data_o), 64'hFFFF_FF80);
        do_load(mk(7'h03, 5'd3, 3'b100), 64'h1002, 64'h0080_0000, 2, 0);
        chk("lbu_data", 64'(w32.rf_data_o), 64'h0000_0080);

        // 64-bit LWU off=4 and LD off=0
        do_load(mk(7'h03, 5'd7, 3'b110), 64'h1004, 64'h8000_0001_0000_0000, 1, 0);
        chk("lwu64", w64.rf_data_o, 64'h0000_0000_8000_0001);
        do_load(mk(7'h03, 5'd8, 3'b011), 64'h2000, 64'h1122_3344_5566_7788, 0, 0);
        chk("ld64", w64.rf_data_o, 64'h1122_3344_5566_7788);

        // JAL link, write to x0, store
        do_op(mk(7'h6F, 5'd1, 3'd0), r64(), 64'h104);
        chk("jal_data", 64'(w32.rf_data_o), 64'h104);
        do_op(mk(7'h33, 5'd0, 3'd0), 64'hDEAD, '0);
        chk("x0_ret", 64'(w32.retire_o), 64'd1);
        do_op(mk(7'h23, 5'd9, 3'd2), 64'h40, '0);

        // misaligned LW
        do_load(mk(7'h03, 5'd9, 3'b010), 64'h1002, 64'hFFFF_FFFF, 1, 0);
`ifdef WB_MISALIGN_TRAP_EN
        chk("lw_mis_trap", 64'(w32.trap_o), 64'd1);
        chk("lw_mis_addr", 64'(w32.trap_addr_o), 64'h1002);
`else
        chk("lw_mis_data", 64'(w32.rf_data_o), 64'd0);
        chk("lw_mis_we", 64'(w32.rf_we_o), 64'd1);
`endif

        // flush together with the load response, flush of an accept
        do_load(mk(7'h03, 5'd10, 3'b010), 64'h3000, 64'h55, 1, 1);
        drive(1, mk(7'h33, 5'd11, 3'd0), 64'h99, '0, 0, '0);
        flush = 1;
        step();
        flush = 0;
        drive(0, '0, '0, '0, 0, '0);
        no_pulse();
        check_all("flush_op", 1);
        drive(1, mk(7'h03, 5'd12, 3'd0), 64'h10, '0, 0, '0);
        flush = 1;
        step();
        flush = 0;
        drive(0, '0, '0, '0, 0, '0);
        check_all("flush_ld", 1);

        // reset in the middle of WAIT_MEM
        drive(1, mk(7'h03, 5'd13, 3'b010), 64'h4000, '0, 0, '0);
        step();
        drive(0, '0, '0, '0, 0, '0);
        step();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            e_rd[k] = '0; e_data[k] = '0; e_taddr[k] = '0;
        end
        no_pulse();
        check_all("rst_mid", 1);
        #1;
        rst_n = 1'b1;
        step();
        check_all("rst_rel", 1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) begin
                a = r64();
                if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
                ins = mk(7'h03, rd, 3'($urandom()));
                do_load(ins, a, r64(), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
            end else if ($urandom_range(0, 9) == 0) begin
                drive(1, mk(7'h33, rd, 3'd0), r64(), r64(), 0, '0);
                flush = 1;
                step();
                flush = 0;
                drive(0, '0, '0, '0, 0, '0);
                no_pulse();
                check_all("rnd_flush", 1);
            end else begin
                opc = NONLOAD[$urandom_range(0, 11)];
                if ($urandom_range(0, 7) == 0) begin
                    opc = 7'($urandom());
                    if (opc == 7'h03) opc = 7'h7F;
                end
                do_op(mk(opc, rd, 3'($urandom())), r64(), r64());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised RV32/RV64 writeback stage with valid/ready handshake toward the memory stage and a decoupled load-response port. It sits between the memory stage and the register file, resolves the result source, and formats load data (byte-lane select plus sign/zero extension). It holds the instruction until a late load response arrives, detects misaligned loads, and drives a single registered register-file write port.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- NREG, 32: register count; RW = $clog2(NREG).
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; drops the held instruction or pending load.
- in_valid_i  in  1  memory stage presents an instruction.
- in_ready_o  out  1  stage can accept; equals (state == IDLE).
- instr_i  in  32  instruction word.
- alu_result_i  in  XLEN  ALU result, or the effective address for loads.
- pc_plus4_i  in  XLEN  link value for JAL/JALR.
- mem_rvalid_i  in  1  load response valid.
- mem_rdata_i  in  XLEN  aligned memory word containing the addressed data.
- rf_we_o  out  1  register-file write enable; one-cycle pulse.
- rf_rd_o  out  RW  destination register.
- rf_data_o  out  XLEN  write data.
- retire_o  out  1  one-cycle pulse per retired instruction.
- trap_o  out  1  misaligned-load trap pulse (only with WB_MISALIGN_TRAP_EN).
- trap_addr_o  out  XLEN  faulting address (only with WB_MISALIGN_TRAP_EN).

## Operation
- FSM states: IDLE, WAIT_MEM. Reset puts the FSM in IDLE and sets every registered output to 0.
- Accept: in_valid_i && in_ready_o.
- Source select, by opcode:
  - OP (0110011), OP-IMM (0010011), LUI (0110111), AUIPC (0010111) -> alu_result_i.
  - JAL (1101111), JALR (1100111) -> pc_plus4_i.
  - LOAD (0000011) -> formatted mem_rdata_i.
  - All other opcodes (store, branch, system, fence) retire with no write.
  - When XLEN=64, OP-32 (0111011) and OP-IMM-32 (0011011) -> alu_result_i.
- Non-load accepted in IDLE: the FSM stays in IDLE and the write/retire fields are registered directly.
- Load accepted in IDLE: the FSM latches instr and address, then moves to WAIT_MEM. mem_rvalid_i is sampled only in WAIT_MEM and ignored in IDLE.
- WAIT_MEM with mem_rvalid_i: format the data, register the write, pulse retire_o, return to IDLE.
- Byte offset off = addr[log2(XLEN/8)-1:0]. The selected field is mem_rdata_i[off*8 +: size].
- Load extension by funct3:
  - LB (000), LH (001), LW (010), LD (011, XLEN=64 only): sign-extend to XLEN.
  - LBU (100), LHU (101), LWU (110, XLEN=64 only): zero-extend to XLEN.
- An undefined funct3 is treated as a misaligned load.
- Misaligned load: LH/LHU with off[0]≠0, LW/LWU with off[1:0]≠0, or LD with off[2:0]≠0.
- rd = instr[11:7] truncated to RW. rd == 0 forces rf_we_o = 0, but retire_o still pulses.
- flush_i has priority over everything:
  - Next cycle the FSM is in IDLE; rf_we_o, retire_o and trap_o are 0.
  - Any accept in the flush cycle is discarded.
  - A load response arriving in the flush cycle is dropped.

## Timing
- Non-load accepted at cycle N: rf_we_o/rf_rd_o/rf_data_o/retire_o valid at N+1 for exactly one cycle.
- Back-to-back non-loads: one per cycle at full throughput.
- Load accepted at N: in_ready_o = 0 from N+1 until the response is consumed.
- Response at cycle M (M ≥ N+1): write at M+1, in_ready_o = 1 at M+1. Minimum load occupancy is 2 cycles.
- rf_rd_o and rf_data_o hold their last value when rf_we_o = 0.
- rst_n asserted mid-load: the pending load is abandoned immediately and all outputs clear asynchronously.

## Configuration
- WB_MISALIGN_TRAP_EN defined:
  - A misaligned load produces no write and no retire.
  - trap_o pulses at the cycle the write would have occurred, with trap_addr_o = address.
- WB_MISALIGN_TRAP_EN undefined:
  - A misaligned load writes 0 to rd (when rd≠0) and retires normally.
  - trap_o and trap_addr_o are tied to 0.

## Test plan
- ADD rd=5, alu=0x1234 accepted at N -> rf_we_o=1, rd=5, data=0x1234 at N+1; three back-to-back ALU ops -> three consecutive writes.
- LB rd=3, addr=0x...2, rdata=0x00800000, response 3 cycles later -> data=0xFFFFFF80; LBU same -> 0x00000080; in_ready_o low until the write cycle.
- XLEN=64: LWU, off=4, rdata=0x80000001_00000000 -> 0x0000000080000001; LD, off=0 -> full word.
- JAL rd=1, pc_plus4=0x104 -> data 0x104; ADD rd=0 -> rf_we_o=0, retire_o=1; SW -> no write, retire_o=1.
- LW at addr 0x...2: with the macro -> trap_o=1, trap_addr_o=addr, no write; without it -> rd written with 0.
- Load pending, flush_i asserted in the same cycle as mem_rvalid_i -> no write, IDLE next cycle. rst_n low mid-WAIT_MEM -> all outputs 0, in_ready_o=1 after release.
